// File: rtl/decode_pipe.sv
// Instruction decode stage: extracts fields and immediates, selects operands from
// the bypass network or register file, stalls on unready producers, and holds one
// decoded instruction in an output register with valid/ready handshaking.
module decode_pipe #(
    parameter int ARCH_LEN = 32,
    parameter int NUM_BYP  = 3,
    parameter int CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [31:0]                  in_inst,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [4:0]                   rf_raddr1,
    output logic [4:0]                   rf_raddr2,
    input  logic [ARCH_LEN-1:0]          rf_rdata1,
    input  logic [ARCH_LEN-1:0]          rf_rdata2,
    input  logic [NUM_BYP-1:0]           byp_valid,
    input  logic [NUM_BYP-1:0]           byp_wen,
    input  logic [NUM_BYP-1:0]           byp_rdy,
    input  logic [5*NUM_BYP-1:0]         byp_dst,
    input  logic [ARCH_LEN*NUM_BYP-1:0]  byp_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ARCH_LEN-1:0]          out_src1,
    output logic [ARCH_LEN-1:0]          out_src2,
    output logic [ARCH_LEN-1:0]          out_imm,
    output logic [4:0]                   out_dst,
    output logic [2:0]                   out_func3,
    output logic [6:0]                   out_func7,
    output logic [6:0]                   out_opcode,
    output logic                         out_wen,
    output logic                         out_is_load,
    output logic                         out_is_store,
    output logic                         out_is_branch,
    output logic                         out_is_jump,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [ARCH_LEN-1:0] src1;
        logic [ARCH_LEN-1:0] src2;
        logic [ARCH_LEN-1:0] imm;
        logic [4:0]          dst;
        logic [2:0]          func3;
        logic [6:0]          func7;
        logic [6:0]          opcode;
        logic                wen;
        logic                is_load;
        logic                is_store;
        logic                is_branch;
        logic                is_jump;
    } dec_t;

    // Returns {hazard, operand}. Scanning oldest to youngest lets the youngest match win.
    function automatic logic [ARCH_LEN:0] pick_operand(
        input logic                        used,
        input logic [4:0]                  r,
        input logic [ARCH_LEN-1:0]         rf,
        input logic [NUM_BYP-1:0]          bv,
        input logic [NUM_BYP-1:0]          bw,
        input logic [NUM_BYP-1:0]          br,
        input logic [5*NUM_BYP-1:0]        bd,
        input logic [ARCH_LEN*NUM_BYP-1:0] bdata
    );
        logic                hit;
        logic                rdy;
        logic [ARCH_LEN-1:0] data;
        hit  = 1'b0;
        rdy  = 1'b0;
        data = rf;
        for (int i = NUM_BYP - 1; i >= 0; i--) begin
            if (bv[i] && bw[i] && bd[5*i +: 5] == r) begin
                hit  = 1'b1;
                rdy  = br[i];
                data = bdata[ARCH_LEN*i +: ARCH_LEN];
            end
        end
        if (!used)
            return {1'b0, rf};
        else if (r == 5'd0)
            return {1'b0, {ARCH_LEN{1'b0}}};
        else if (hit && !rdy)
            return {1'b1, data};
        else
            return {1'b0, data};
    endfunction

    logic [6:0]          opcode;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                use_rs1;
    logic                use_rs2;
    logic [31:0]         imm32;
    logic [ARCH_LEN:0]   op1;
    logic [ARCH_LEN:0]   op2;
    logic                hazard;
    logic                accept;
    dec_t                dec_d;
    dec_t                dec_q;
    logic                out_valid_d;
    logic                out_valid_q;
    logic [CNT_W-1:0]    stall_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q;

    assign opcode    = in_inst[6:0];
    assign rs1       = in_inst[19:15];
    assign rs2       = in_inst[24:20];
    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        imm32   = 32'd0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        unique case (opcode)
            OP_REG: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                use_rs1 = 1'b1;
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: imm32 = {in_inst[31:12], 12'd0};
            OP_JAL: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                             in_inst[20], in_inst[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    always_comb begin
        op1 = pick_operand(use_rs1, rs1, rf_rdata1, byp_valid, byp_wen, byp_rdy, byp_dst, byp_data);
        op2 = pick_operand(use_rs2, rs2, rf_rdata2, byp_valid, byp_wen, byp_rdy, byp_dst, byp_data);
    end

    assign hazard   = in_valid && (op1[ARCH_LEN] || op2[ARCH_LEN]);
    assign in_ready = rst && !hazard && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_d           = dec_q;
        out_valid_d     = out_valid_q;
        stall_cnt_d     = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d     = 1'b1;
            dec_d.src1      = op1[ARCH_LEN-1:0];
            dec_d.src2      = op2[ARCH_LEN-1:0];
            dec_d.imm       = ARCH_LEN'($signed(imm32));
            dec_d.dst       = in_inst[11:7];
            dec_d.func3     = in_inst[14:12];
            dec_d.func7     = in_inst[31:25];
            dec_d.opcode    = opcode;
            dec_d.wen       = (in_inst[11:7] != 5'd0) &&
                              (opcode == OP_REG || opcode == OP_IMM || opcode == OP_LOAD ||
                               opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL ||
                               opcode == OP_JALR);
            dec_d.is_load   = (opcode == OP_LOAD);
            dec_d.is_store  = (opcode == OP_STORE);
            dec_d.is_branch = (opcode == OP_BRANCH);
            dec_d.is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (hazard && !flush && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the payload register is reset too, since its reset value is externally visible.
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dec_q       <= dec_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_src1      = dec_q.src1;
    assign out_src2      = dec_q.src2;
    assign out_imm       = dec_q.imm;
    assign out_dst       = dec_q.dst;
    assign out_func3     = dec_q.func3;
    assign out_func7     = dec_q.func7;
    assign out_opcode    = dec_q.opcode;
    assign out_wen       = dec_q.wen;
    assign out_is_load   = dec_q.is_load;
    assign out_is_store  = dec_q.is_store;
    assign out_is_branch = dec_q.is_branch;
    assign out_is_jump   = dec_q.is_jump;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: reset, decode, bypass priority, hazard stall,
// backpressure, flush and mid-transfer reset, each checked against hand values.
module tb_decode_pipe;

    localparam int AL = 32;
    localparam int NB = 3;
    localparam int CW = 32;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [31:0]    in_inst;
    logic           in_ready;
    logic           flush;
    logic [4:0]     rf_raddr1, rf_raddr2;
    logic [AL-1:0]  rf_rdata1, rf_rdata2;
    logic [NB-1:0]  byp_valid, byp_wen, byp_rdy;
    logic [5*NB-1:0]  byp_dst;
    logic [AL*NB-1:0] byp_data;
    logic           out_valid;
    logic           out_ready;
    logic [AL-1:0]  out_src1, out_src2, out_imm;
    logic [4:0]     out_dst;
    logic [2:0]     out_func3;
    logic [6:0]     out_func7, out_opcode;
    logic           out_wen, out_is_load, out_is_store, out_is_branch, out_is_jump;
    logic [CW-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    decode_pipe #(.ARCH_LEN(AL), .NUM_BYP(NB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
        .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .byp_valid(byp_valid), .byp_wen(byp_wen), .byp_rdy(byp_rdy),
        .byp_dst(byp_dst), .byp_data(byp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm),
        .out_dst(out_dst), .out_func3(out_func3), .out_func7(out_func7),
        .out_opcode(out_opcode), .out_wen(out_wen), .out_is_load(out_is_load),
        .out_is_store(out_is_store), .out_is_branch(out_is_branch),
        .out_is_jump(out_is_jump), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic set_byp(input int i, input logic v, input logic w, input logic r,
                           input logic [4:0] d, input logic [AL-1:0] data);
        byp_valid[i]            = v;
        byp_wen[i]              = w;
        byp_rdy[i]              = r;
        byp_dst[5*i +: 5]       = d;
        byp_data[AL*i +: AL]    = data;
    endtask

    task automatic clear_byp();
        byp_valid = '0;
        byp_wen   = '0;
        byp_rdy   = '0;
        byp_dst   = '0;
        byp_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00293; flush = 1'b0; out_ready = 1'b1;
        rf_rdata1 = 32'hDEAD_0001; rf_rdata2 = 32'hDEAD_0002;
        clear_byp();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_imm !== '0 || out_dst !== 5'd0 || out_wen !== 1'b0) begin errors++; $display("FAIL reset_fields imm %h dst %0d wen %0b want 0", out_imm, out_dst, out_wen); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_addi();
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'hFFF00293;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready got %0b want 1", in_ready); end
        checks++; if (rf_raddr1 !== 5'd0 || rf_raddr2 !== 5'd31) begin errors++; $display("FAIL addi_raddr got %0d/%0d want 0/31", rf_raddr1, rf_raddr2); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b want 1", out_valid); end
        checks++; if (out_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", out_imm); end
        checks++; if (out_dst !== 5'd5 || out_wen !== 1'b1) begin errors++; $display("FAIL addi_dst got %0d wen %0b want 5/1", out_dst, out_wen); end
        checks++; if (out_src1 !== 32'd0) begin errors++; $display("FAIL addi_src1 got %h want 0", out_src1); end
        checks++; if (out_opcode !== 7'b0010011 || out_is_jump !== 1'b0) begin errors++; $display("FAIL addi_opcode got %b jump %0b", out_opcode, out_is_jump); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_bypass_priority();
        @(negedge clk);
        clear_byp();
        set_byp(0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h11);
        set_byp(2, 1'b1, 1'b1, 1'b1, 5'd1, 32'h22);
        rf_rdata2 = 32'h2222;
        in_valid = 1'b1; in_inst = 32'h002081B3;
        @(posedge clk); #1;
        checks++; if (out_src1 !== 32'h11) begin errors++; $display("FAIL byp_youngest got %h want 11", out_src1); end
        checks++; if (out_src2 !== 32'h2222) begin errors++; $display("FAIL byp_rf_src2 got %h want 2222", out_src2); end
        checks++; if (out_dst !== 5'd3 || out_imm !== 32'd0) begin errors++; $display("FAIL add_fields dst %0d imm %h want 3/0", out_dst, out_imm); end
        @(negedge clk);
        set_byp(0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        checks++; if (out_src1 !== 32'h22) begin errors++; $display("FAIL byp_oldest got %h want 22", out_src1); end
    endtask

    task automatic test_hazard_stall();
        @(negedge clk);
        clear_byp();
        set_byp(0, 1'b1, 1'b1, 1'b0, 5'd2, 32'h33);
        in_valid = 1'b1; in_inst = 32'h002081B3;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %0b want 0", c, in_ready); end
            @(negedge clk);
        end
        byp_rdy[0] = 1'b1;
        #1;
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt got %0d want 3", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %0b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_src2 !== 32'h33) begin errors++; $display("FAIL stall_accept valid %0b src2 %h want 1/33", out_valid, out_src2); end
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_hold got %0d want 3", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        clear_byp();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h123453B7;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %0b want 0", c, in_ready); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_src2 !== 32'h33 || out_dst !== 5'd3) begin errors++; $display("FAIL bp_stable cycle %0d valid %0b src2 %h dst %0d", c, out_valid, out_src2, out_dst); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %0b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'h12345000 || out_dst !== 5'd7) begin errors++; $display("FAIL b2b_lui valid %0b imm %h dst %0d", out_valid, out_imm, out_dst); end
        @(negedge clk);
        in_inst = 32'h0020A423;
        rf_rdata1 = 32'h1000;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_is_store !== 1'b1 || out_wen !== 1'b0 || out_imm !== 32'd8) begin errors++; $display("FAIL b2b_sw valid %0b st %0b wen %0b imm %h", out_valid, out_is_store, out_wen, out_imm); end
        checks++; if (out_src1 !== 32'h1000 || out_func3 !== 3'b010) begin errors++; $display("FAIL b2b_sw_ops src1 %h f3 %b", out_src1, out_func3); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'hFFF00293; flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        checks++; if (out_dst === 5'd5) begin errors++; $display("FAIL flush_presented dst %0d want not 5", out_dst); end
        @(negedge clk);
        set_byp(0, 1'b1, 1'b1, 1'b0, 5'd2, 32'h44);
        in_inst = 32'h002081B3;
        @(posedge clk); #1;
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL flush_stall got %0d want 3", stall_cnt); end
        @(negedge clk);
        flush = 1'b0; clear_byp(); in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'hFFF00293;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_setup got %0b want 1", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_imm !== '0 || stall_cnt !== '0) begin errors++; $display("FAIL rmid_clear valid %0b imm %h stall %0d", out_valid, out_imm, stall_cnt); end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; in_inst = 32'h008000EF;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'd8) begin errors++; $display("FAIL jal_imm valid %0b imm %h want 1/8", out_valid, out_imm); end
        checks++; if (out_is_jump !== 1'b1 || out_wen !== 1'b1 || out_dst !== 5'd1) begin errors++; $display("FAIL jal_flags jump %0b wen %0b dst %0d", out_is_jump, out_wen, out_dst); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass_priority();
        test_hazard_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
